// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver (and the matching transmitter):
//   - DATA_BITS            : data bits per frame (8N1 framing, LSB first)
//   - CLKS_PER_BIT_DEFAULT : default clk cycles per serial bit
//   - rx_state_t           : receiver FSM state encoding
// No ports; package only.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_sipo.sv
// -----------------------------------------------------------------------------
// sipo
// Serial-in parallel-out shift register. On each enabled cycle the new bit
// enters the MSB and the register shifts right, so for a UART frame sent LSB
// first the first bit received ends up in bit 0 after WIDTH shifts.
// Ports:
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset, clears the register
//   shift_en     : shift one bit in this cycle
//   serial_in    : bit to shift in
//   parallel_out : current register contents
// -----------------------------------------------------------------------------
module sipo
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (shift_en) begin
      data_d = {serial_in, data_q[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign parallel_out = data_q;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with mid-bit sampling, stop-bit checking and break
// handling. The serial line is synchronized through two flops; every decision
// is taken on the synchronized bit (rxs).
// Ports:
//   clk          : single system clock, rising edge
//   rst          : synchronous active-high reset
//   rx_serial_in : asynchronous serial line, idles high
//   rx_data_out  : last correctly framed byte, held until the next good frame
//   rx_valid     : one-cycle pulse, rx_data_out updated in the same cycle
//   rx_frame_err : one-cycle pulse when the stop bit samples low
//   rx_busy      : high in every FSM state except IDLE
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS  // only 8 is supported
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  import uart_pkg::*;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TIMER_MID  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);

  // Input synchronizer. Reset to 1 so the line reads idle out of reset.
  logic sync1_q, sync2_q;
  logic rxs;

  // sync_ok_q fills with ones once the synchronizer holds real line samples
  // instead of its reset value; armed_q then latches the first genuine high.
  // IDLE accepts a start bit only when armed, so a line that is already low
  // when reset releases (mid-frame abort) cannot start a bogus frame.
  logic [1:0] sync_ok_q, sync_ok_d;
  logic       armed_q, armed_d;

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 shift_en;
  logic [DATA_BITS-1:0] shift_data;

  assign rxs = sync2_q;

  sipo #(
    .WIDTH (DATA_BITS)
  ) u_sipo (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (shift_en),
    .serial_in    (rxs),
    .parallel_out (shift_data)
  );

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    shift_en  = 1'b0;
    sync_ok_d = {sync_ok_q[0], 1'b1};
    armed_d   = armed_q | (sync_ok_q[1] & rxs);

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (armed_q && !rxs) begin
          state_d = START;
        end
      end

      START: begin
        // Mid start bit: still low means a real frame, high means a glitch.
        if (timer_q == TIMER_MID) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DATA: begin
        if (timer_q == TIMER_LAST) begin
          timer_d  = '0;
          shift_en = 1'b1;
          // Leave on the last index instead of letting the counter wrap.
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      STOP: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (rxs) begin
            data_d  = shift_data;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK_WAIT;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      BREAK_WAIT: begin
        // Hold off until the line returns high so a break reports only once.
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the synchronizer resets to the idle level (1) and the shift
  // register and output byte to zero; every flop here has a defined reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync_ok_q <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= rx_serial_in;
      sync2_q   <= sync1_q;
      sync_ok_q <= sync_ok_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rx_data_out  = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver (CLKS_PER_BIT=16). The stimulus pushes the
// expected pulse (good byte or frame error with the held byte) into a queue
// before driving each frame; an independent monitor pops and compares every
// rx_valid / rx_frame_err pulse it sees.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB   = 16;
  localparam int CLK_P = 100;
  localparam int BIT_T = CPB * CLK_P;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_serial_in (rx),
    .rx_data_out  (rx_data_out),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #(CLK_P / 2) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back('{is_err: 1'b0, data: b});
    last_good = b;
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, data: last_good});
  endtask

  // Drives one 8N1 frame; bit_t sets the sender's own bit period.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop;
    #(bit_t);
  endtask

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    logic prev_pulse;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid || rx_frame_err) begin
        check("pulse_overlap", 32'(rx_valid & rx_frame_err), 32'd0);
        if (prev_pulse) begin
          check("pulse_width_one_cycle", 32'(prev_pulse), 32'd0);
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h, expected none",
                   rx_valid, rx_frame_err, rx_data_out);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_is_err", 32'(rx_frame_err), 32'(e.is_err));
          check("rx_data_out", 32'(rx_data_out), 32'(e.data));
        end
      end
      prev_pulse = rx_valid | rx_frame_err;
    end
  end

  initial begin : watchdog
    #(CLK_P * 60000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int cnt;
    int busy_cnt;

    // Reset values.
    repeat (4) @(negedge clk);
    check("reset_data", 32'(rx_data_out), 32'h00);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_err", 32'(rx_frame_err), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single frame A5 with latency measurement from the pin falling edge.
    expect_byte(8'hA5);
    cnt = 0;
    fork
      send_byte(8'hA5, 1'b1, BIT_T);
      begin
        while (!rx_valid && cnt < 400) begin
          @(negedge clk);
          cnt++;
        end
      end
    join
    check("latency_155_pm1", 32'(cnt >= 154 && cnt <= 156), 32'd1);
    repeat (30) @(negedge clk);

    // Back-to-back frames, no idle gap.
    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h19);
    send_byte(8'h00, 1'b1, BIT_T);
    send_byte(8'hFF, 1'b1, BIT_T);
    send_byte(8'h19, 1'b1, BIT_T);
    repeat (30) @(negedge clk);

    // 4-cycle low glitch on an idle line.
    rx = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (i == 3) rx = 1'b1;
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_seen", 32'(busy_cnt >= 1), 32'd1);
    check("glitch_busy_le_10", 32'(busy_cnt <= 10), 32'd1);
    check("glitch_back_idle", 32'(rx_busy), 32'd0);

    // Bad stop bit followed by a held-low line, then a good frame.
    expect_err();
    send_byte(8'h3C, 1'b0, BIT_T);
    #(100 * CLK_P);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("data_held_after_err", 32'(rx_data_out), 32'h19);
    expect_byte(8'h5A);
    send_byte(8'h5A, 1'b1, BIT_T);
    repeat (30) @(negedge clk);

    // Reset during data bit 4 of C3; sender keeps driving the rest of it.
    fork
      send_byte(8'hC3, 1'b1, BIT_T);
      begin
        #(BIT_T * 11 / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("midreset_data", 32'(rx_data_out), 32'h00);
        check("midreset_valid", 32'(rx_valid), 32'd0);
        check("midreset_err", 32'(rx_frame_err), 32'd0);
        check("midreset_busy", 32'(rx_busy), 32'd0);
        busy_cnt = 0;
        repeat (10) begin
          @(negedge clk);
          if (rx_busy) busy_cnt++;
        end
        check("no_start_on_low_after_reset", 32'(busy_cnt), 32'd0);
      end
    join
    repeat (30) @(negedge clk);
    expect_byte(8'h81);
    send_byte(8'h81, 1'b1, BIT_T);
    repeat (30) @(negedge clk);

    // Sender bit period skewed +3% and -3%.
    expect_byte(8'h55);
    send_byte(8'h55, 1'b1, BIT_T * 103 / 100);
    repeat (30) @(negedge clk);
    expect_byte(8'h55);
    send_byte(8'h55, 1'b1, BIT_T * 97 / 100);
    repeat (40) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16; clk cycles per serial bit; SHALL be even and >= 4.
REQ-002 Parameter DATA_BITS, default 8; data bits per frame; only 8 is supported.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port rx_serial_in  input  1  asynchronous serial line; idles high; 8N1 frame, LSB first.
REQ-006 Port rx_data_out  output  8  last correctly framed byte; held until the next good frame.
REQ-007 Port rx_valid  output  1  one-cycle pulse; rx_data_out updated in the same cycle.
REQ-008 Port rx_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 Port rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 rx_serial_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized bit (rxs), giving 2 cycles of input latency.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-012 IDLE: rxs==0 -> START with bit-timer cleared; otherwise stay.
REQ-013 START: after CLKS_PER_BIT/2 cycles (mid start bit), rxs==0 -> DATA with timer and bit index cleared; rxs==1 -> IDLE (glitch rejected, no pulse).
REQ-014 DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register, shifting right with the new bit entering the MSB, so bit 0 arrives first.
REQ-015 DATA: after the 8th sample -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample rxs.
REQ-017 STOP sample ==1: on the next edge, rx_data_out <= shift register, rx_valid=1 for exactly one cycle, -> IDLE.
REQ-018 STOP sample ==0: rx_frame_err=1 for one cycle, rx_data_out unchanged, -> BREAK_WAIT.
REQ-019 BREAK_WAIT: stay until rxs==1, then -> IDLE, so a held-low line (break) yields exactly one rx_frame_err and no retriggering.
REQ-020 The bit-timer SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each sample; its width is $clog2(CLKS_PER_BIT).
REQ-021 The bit index SHALL count 0..7; the 3-bit counter is not allowed to wrap into a 9th sample.
REQ-022 rx_valid and rx_frame_err SHALL never be high in the same cycle.
REQ-023 A new start bit is accepted from the first IDLE cycle after REQ-017, so back-to-back frames receive with no lost bits.
REQ-024 Total latency from the falling edge of the start bit at the pin to rx_valid SHALL be 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, +/-1 for edge phase.

Reset
REQ-025 While rst==1 at a clk edge: state=IDLE; timer, bit index and shift register =0; rx_data_out=8'h00; rx_valid=0; rx_frame_err=0; rx_busy=0.
REQ-026 Synchronizer flops SHALL reset to 1 (line idle).
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_valid or rx_frame_err pulse.
REQ-028 After reset deasserts, reception starts only from a fresh falling edge.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state encoding, DATA_BITS and the default CLKS_PER_BIT, shared with the transmitter.
REQ-030 One sub-module, sipo (serial-in parallel-out shift register with shift-enable, 8 bits, synchronous active-high reset), SHALL implement REQ-014.
REQ-031 The FSM, timer and output registers SHALL reside in uart_receiver.

Verification
REQ-032 Reset then frame 8'hA5 (CLKS_PER_BIT=16) -> one rx_valid pulse, rx_data_out=8'hA5, rx_frame_err never high.
REQ-033 Back-to-back frames 8'h00, 8'hFF, 8'h19 with no idle gap -> three rx_valid pulses with data in that order.
REQ-034 Low glitch of 4 cycles on an idle line -> returns to IDLE; no rx_valid and no rx_frame_err; rx_busy high for at most 8+2 cycles.
REQ-035 Frame 8'h3C with stop bit driven 0, line low a further 100 cycles, then a good 8'h5A -> one rx_frame_err, rx_data_out stays 8'h3C's predecessor, then rx_valid with 8'h5A.
REQ-036 rst pulsed during data bit 4 of 8'hC3 -> outputs at reset values next cycle, no pulses; a following 8'h81 is received correctly.
REQ-037 Sender bit period skewed +/-3% against CLKS_PER_BIT=16 on 8'h55 -> correct reception.
